rom_read_arbiter: RTL

//  Shares the single sprite/screen ROM multiplexer (4-bit ROM id, 16-bit address, 16-bit RGB565 data) between NUM_REQ pixel requesters.

---
 rtl/rom_read_arbiter_if.sv | 26 ++
 rtl/rom_read_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter_if.sv
// Request, ROM-mux and response signals shared between the pixel requesters
// and rom_read_arbiter. The arbiter uses the slave view; the requester/ROM side uses master.
interface rom_read_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [4*NUM_REQ-1:0]  req_rom_id;
  logic [16*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_ready;
  logic [3:0]            rom_id;
  logic [15:0]           rom_addr;
  logic [15:0]           rom_data;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_data;
  logic                  busy;

  modport slave (
    input  req_valid, req_rom_id, req_addr, rom_data,
    output req_ready, rom_id, rom_addr, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_rom_id, req_addr, rom_data,
    input  req_ready, rom_id, rom_addr, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one ROM mux between NUM_REQ pixel requesters, with a
// tag pipeline that routes returned pixels. Define ROM_ARB_PRIORITY_EN to make requester 0 strict-priority.
module rom_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset,
  rom_read_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [3:0]         win_id;
  logic [15:0]        win_addr;

  logic [3:0]         rom_id_q;
  logic [15:0]        rom_addr_q;
  tag_t               tag_q [READ_LATENCY+1];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q;
  logic               busy_d;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    int cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_ptr_d  = rr_ptr_q;
`ifdef ROM_ARB_PRIORITY_EN
    if (bus.req_valid[0]) begin
      grant_vld = 1'b1;
    end else begin
      // Pointer value 0 (post-reset) behaves like 1: requester 0 never joins the ring.
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        cand = ((rr_ptr_q == '0) ? 1 : int'(rr_ptr_q)) + k;
        if (cand >= NUM_REQ) cand -= NUM_REQ - 1;
        if (!grant_vld && bus.req_valid[IDX_W'(cand)]) begin
          grant_vld = 1'b1;
          grant_idx = IDX_W'(cand);
        end
      end
    end
    if (!reset) grant_vld = 1'b0;
    if (grant_vld && grant_idx != '0) begin
      rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? IDX_W'(1) : grant_idx + IDX_W'(1);
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand -= NUM_REQ;
      if (!grant_vld && bus.req_valid[IDX_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    if (!reset) grant_vld = 1'b0;
    if (grant_vld) begin
      rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
    end
`endif
  end

  always_comb begin
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  // One-hot select of the winner's id/address.
  always_comb begin
    win_id   = '0;
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        win_id   = bus.req_rom_id[4*i +: 4];
        win_addr = bus.req_addr[16*i +: 16];
      end
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    if (tag_q[READ_LATENCY].vld) rsp_valid_d[tag_q[READ_LATENCY].idx] = 1'b1;
  end

  always_comb begin
    busy_d = 1'b0;
    for (int s = 0; s <= READ_LATENCY; s++) busy_d = busy_d | tag_q[s].vld;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      rom_id_q    <= '0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int s = 0; s <= READ_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (grant_vld) begin
        rom_id_q   <= win_id;
        rom_addr_q <= win_addr;
      end
      tag_q[0] <= '{vld: grant_vld, idx: grant_idx};
      for (int s = 1; s <= READ_LATENCY; s++) tag_q[s] <= tag_q[s-1];
      rsp_valid_q <= rsp_valid_d;
      if (tag_q[READ_LATENCY].vld) rsp_data_q <= bus.rom_data;
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.rom_id    = rom_id_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_d;

endmodule
